// File: rtl/frodo_pkg.sv
// rtl/frodo_pkg.sv - shared types and constants for the FrodoKEM matrix datapath
package frodo_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    localparam int FRODO_N           = 1344;
    // Four 16-bit matrix elements are packed into each 64-bit word.
    localparam int ROW_WORDS_DEFAULT = FRODO_N / 4;
    localparam int WORD_SHIFT        = 3;

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, one write port and one registered read port
module sdp_ram #(
    parameter int DEPTH = 672,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/hash_row_buffer.sv
// rtl/hash_row_buffer.sv - ping-pong row store between matrix generator and HASH read port
module hash_row_buffer
    import frodo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ROW_WORDS  = ROW_WORDS_DEFAULT,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  gen_valid,
    input  logic [DATA_WIDTH-1:0] gen_data,
    output logic                  gen_ready,
    input  logic [ADDR_WIDTH-1:0] addr_HASH,
    output logic [DATA_WIDTH-1:0] bram_data_HASH,
    output logic                  HASH_ready,
    input  logic                  row_release,
    output logic [15:0]           rows_filled,
    output logic                  err
);

    localparam int RAM_DEPTH = 2 * ROW_WORDS;
    localparam int RAM_AW    = $clog2(RAM_DEPTH);

    bank_state_t           state_q [2];
    bank_state_t           state_d [2];
    logic                  wbank_q;
    logic                  rbank_q;
    logic [CNT_WIDTH-1:0]  wcnt_q;
    logic [15:0]           rows_q;
    logic                  ready_en_q;
    logic                  rd_valid_q;
    logic                  err_q;

    logic                  accept;
    logic                  last_word;
    logic                  release_ok;
    logic                  rd_in_range;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [CNT_WIDTH-1:0]  rd_idx;
    logic [RAM_AW-1:0]     waddr;
    logic [RAM_AW-1:0]     raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // ready_en_q holds gen_ready low for the cycle following reset.
    assign gen_ready   = ready_en_q && (state_q[wbank_q] != FULL);
    assign HASH_ready  = (state_q[rbank_q] == FULL);
    assign accept      = gen_valid && gen_ready && !flush;
    assign last_word   = accept && (wcnt_q == CNT_WIDTH'(ROW_WORDS - 1));
    assign release_ok  = row_release && HASH_ready && !flush;

    assign word_idx    = addr_HASH >> WORD_SHIFT;
    assign rd_in_range = (word_idx < ADDR_WIDTH'(ROW_WORDS));
    // Out-of-range indices are clamped so the RAM is never addressed past its end.
    assign rd_idx      = rd_in_range ? word_idx[CNT_WIDTH-1:0] : '0;

    assign waddr = wbank_q ? RAM_AW'(ROW_WORDS) + RAM_AW'(wcnt_q) : RAM_AW'(wcnt_q);
    assign raddr = rbank_q ? RAM_AW'(ROW_WORDS) + RAM_AW'(rd_idx) : RAM_AW'(rd_idx);

    sdp_ram #(
        .DEPTH (RAM_DEPTH),
        .WIDTH (DATA_WIDTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (waddr),
        .wdata (gen_data),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            if (flush) begin
                state_d[b] = EMPTY;
            end else begin
                if (release_ok && (rbank_q == 1'(b))) begin
                    state_d[b] = EMPTY;
                end
                if (accept && (wbank_q == 1'(b))) begin
                    state_d[b] = last_word ? FULL : FILLING;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            wcnt_q     <= '0;
            rows_q     <= '0;
            ready_en_q <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            ready_en_q <= 1'b1;
            if (flush) begin
                wbank_q    <= 1'b0;
                rbank_q    <= 1'b0;
                wcnt_q     <= '0;
                rows_q     <= '0;
                rd_valid_q <= 1'b0;
                err_q      <= 1'b0;
            end else begin
                if (last_word) begin
                    wcnt_q  <= '0;
                    wbank_q <= !wbank_q;
                    rows_q  <= rows_q + 16'd1;
                end else if (accept) begin
                    wcnt_q <= wcnt_q + CNT_WIDTH'(1);
                end
                if (release_ok) begin
                    rbank_q <= !rbank_q;
                end
                // Early polling while no row is ready is legal and never flags.
                if ((row_release && !HASH_ready) || (HASH_ready && !rd_in_range)) begin
                    err_q <= 1'b1;
                end
                rd_valid_q <= HASH_ready && rd_in_range;
            end
        end
    end

    assign bram_data_HASH = rd_valid_q ? ram_rdata : '0;
    assign rows_filled    = rows_q;
    assign err            = err_q;

endmodule
